// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Instruction fetch front-end. Generates sequential word PCs, issues reads
// over a valid/ready request port, collects in-order responses into a small
// prefetch FIFO of {pc, instr} pairs, and handles redirects by flushing the
// FIFO and discarding responses that are still in flight.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   fetch_en_in              allow new requests
//   redirect_valid_in/pc_in  single-cycle redirect and its target
//   instr_addr/valid_out     request to memory, instr_ready_in accepts it
//   instr_rdata_valid/in     in-order read responses
//   fetch_valid/pc/instr_out FIFO head toward decode, fetch_ready_in pops it
//   outstanding_out          accepted requests not yet answered
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en_in,
    input  logic          redirect_valid_in,
    input  logic [31:0]   redirect_pc_in,
    output logic [31:0]   instr_addr_out,
    output logic          instr_valid_out,
    input  logic          instr_ready_in,
    input  logic          instr_rdata_valid_in,
    input  logic [31:0]   instr_rdata_in,
    output logic          fetch_valid_out,
    output logic [31:0]   fetch_pc_out,
    output logic [31:0]   fetch_instr_out,
    input  logic          fetch_ready_in,
    output logic [CW-1:0] outstanding_out
);

    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_d [FIFO_DEPTH];
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [31:0]   instr_mem_d [FIFO_DEPTH];

    logic [31:0] redirect_tgt;
    logic [CW:0] occupancy;
    logic        issue_ok;
    logic        accept;
    logic        resp_ok;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_in[1:0];

    always_comb begin
        redirect_tgt = {redirect_pc_in[31:2], 2'b00};
        // Occupied slots plus in-flight requests; each accepted request owns a
        // slot so the FIFO cannot overflow.
        occupancy    = {1'b0, count_q} + {1'b0, outstanding_q};
        fifo_empty   = (count_q == '0);
        issue_ok     = fetch_en_in & ~redirect_valid_in & (occupancy < DEPTH_C);
        accept       = issue_ok & instr_ready_in;
        // A response with nothing outstanding is a protocol error and ignored.
        resp_ok      = instr_rdata_valid_in & (outstanding_q != '0);
        push         = resp_ok & ~redirect_valid_in & (drop_cnt_q == '0);
        pop          = ~fifo_empty & ~redirect_valid_in & fetch_ready_in;
    end

    // Request valid is forced low while reset is asserted; the flops need no
    // such qualification because reset holds them.
    assign instr_valid_out = issue_ok & rst;
    assign instr_addr_out  = fetch_pc_q;
    assign fetch_valid_out = ~fifo_empty & ~redirect_valid_in;
    assign fetch_pc_out    = fifo_empty ? 32'h0 : pc_mem_q[rd_ptr_q];
    assign fetch_instr_out = fifo_empty ? 32'h0 : instr_mem_q[rd_ptr_q];
    assign outstanding_out = outstanding_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp_ok);
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pc_mem_d      = pc_mem_q;
        instr_mem_d   = instr_mem_q;

        if (redirect_valid_in) begin
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            // Everything still in flight belongs to the old stream, minus a
            // response that is being discarded this very cycle.
            drop_cnt_d = outstanding_q - CW'(resp_ok);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (resp_ok && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                pc_mem_d[wr_ptr_q]    = resp_pc_q;
                instr_mem_d[wr_ptr_q] = instr_rdata_in;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                resp_pc_d             = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= 32'h0;
                instr_mem_q[i] <= 32'h0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pc_mem_q      <= pc_mem_d;
            instr_mem_q   <= instr_mem_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] iaddr;
    logic        ivalid;
    logic        iready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fvalid;
    logic [31:0] fpc;
    logic [31:0] finstr;
    logic        fready;
    logic [2:0]  outst;

    instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_en_in          (fetch_en),
        .redirect_valid_in    (redir),
        .redirect_pc_in       (redir_pc),
        .instr_addr_out       (iaddr),
        .instr_valid_out      (ivalid),
        .instr_ready_in       (iready),
        .instr_rdata_valid_in (rvalid),
        .instr_rdata_in       (rdata),
        .fetch_valid_out      (fvalid),
        .fetch_pc_out         (fpc),
        .fetch_instr_out      (finstr),
        .fetch_ready_in       (fready),
        .outstanding_out      (outst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: architectural view of the fetch stream
    logic [31:0] m_fpc, m_rpc;
    int          m_out, m_drop;
    logic [63:0] m_q[$];

    // Memory model: in-order responses with per-request latency
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];
    int    last_due;
    bit    mem_hold;
    int    lat_lo = 1;
    int    lat_hi = 1;
    int    dut_accepts;

    logic        s_iv, s_fv;
    logic [31:0] s_ia, s_fp, s_fi;

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        fr;
        logic        iv;
        logic [31:0] ia;
        logic        fv;
        logic [31:0] fp;
        logic [31:0] fi;
        logic [2:0]  o;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fpc    = RPC;
        m_rpc    = RPC;
        m_out    = 0;
        m_drop   = 0;
        m_q.delete();
        mem_q.delete();
        last_due = 0;
        mem_hold = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        fetch_en = 1'b0;
        redir    = 1'b0;
        redir_pc = 32'h0;
        iready   = 1'b0;
        rvalid   = 1'b0;
        rdata    = 32'h0;
        fready   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: called at a falling edge with the control inputs set.
    task automatic step();
        logic        exp_iv, exp_fv, acc, pp, rsp;
        logic [31:0] exp_fp, exp_fi;
        mreq_t       r;
        int          due;
        rsp = 1'b0;
        if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            r      = mem_q.pop_front();
            rvalid = 1'b1;
            rdata  = r.addr + 32'h100;
            rsp    = 1'b1;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        #1;
        exp_iv = fetch_en && !redir && ((m_q.size() + m_out) < DEPTH);
        exp_fv = (m_q.size() > 0) && !redir;
        exp_fp = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
        exp_fi = (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0;
        chk("instr_valid", 32'(ivalid), 32'(exp_iv));
        chk("instr_addr", iaddr, m_fpc);
        chk("fetch_valid", 32'(fvalid), 32'(exp_fv));
        chk("fetch_pc", fpc, exp_fp);
        chk("fetch_instr", finstr, exp_fi);
        chk("outstanding", 32'(outst), 32'(m_out));
        s_iv = ivalid; s_ia = iaddr; s_fv = fvalid; s_fp = fpc; s_fi = finstr;
        if (ivalid && iready) dut_accepts++;
        acc = exp_iv && iready;
        pp  = exp_fv && fready;
        if (redir) begin
            m_q.delete();
            m_fpc  = {redir_pc[31:2], 2'b00};
            m_rpc  = m_fpc;
            m_drop = m_out - (rsp ? 1 : 0);
            m_out  = m_drop;
        end else begin
            if (pp) void'(m_q.pop_front());
            if (rsp) begin
                if (m_drop > 0) m_drop--;
                else begin
                    m_q.push_back({m_rpc, rdata});
                    m_rpc = m_rpc + 32'd4;
                end
                m_out--;
            end
            if (acc) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: m_fpc, due: due});
                m_fpc = m_fpc + 32'd4;
                m_out++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        //             rv  rd        fr   iv  ia        fv  fp        fi        o
        vecs[0]  = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h000, 3'd0};
        vecs[1]  = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h000, 3'd1};
        vecs[2]  = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h100, 3'd1};
        vecs[3]  = '{1'b1, 32'h108, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h104, 3'd1};
        vecs[4]  = '{1'b1, 32'h10C, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h108, 3'd1};
        vecs[5]  = '{1'b1, 32'h110, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h10C, 3'd1};
        vecs[6]  = '{1'b1, 32'h114, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C, 32'h10C, 3'd1};
        vecs[7]  = '{1'b1, 32'h118, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 32'h10C, 3'd1};
        vecs[8]  = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 32'h10C, 3'd0};
        vecs[9]  = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h0C, 32'h10C, 3'd0};
        vecs[10] = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 32'h110, 3'd0};
        vecs[11] = '{1'b1, 32'h11C, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'h110, 3'd1};
        vecs[12] = '{1'b0, 32'h000, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'h110, 3'd0};

        // Reset values, then 1-cycle-latency stream with a backpressure window
        do_reset();
        chk("reset_outstanding", 32'(outst), 32'h0);
        chk("reset_addr", iaddr, RPC);
        for (int i = 0; i < 13; i++) begin
            fetch_en = 1'b1;
            iready   = 1'b1;
            redir    = 1'b0;
            rvalid   = vecs[i].rv;
            rdata    = vecs[i].rd;
            fready   = vecs[i].fr;
            #1;
            chk($sformatf("tbl%0d_ivalid", i), 32'(ivalid), 32'(vecs[i].iv));
            chk($sformatf("tbl%0d_iaddr", i), iaddr, vecs[i].ia);
            chk($sformatf("tbl%0d_fvalid", i), 32'(fvalid), 32'(vecs[i].fv));
            chk($sformatf("tbl%0d_fpc", i), fpc, vecs[i].fp);
            chk($sformatf("tbl%0d_finstr", i), finstr, vecs[i].fi);
            chk($sformatf("tbl%0d_outst", i), 32'(outst), 32'(vecs[i].o));
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end

        // Backpressure from reset
        do_reset();
        lat_lo = 1; lat_hi = 1;
        fetch_en = 1'b1; iready = 1'b1; fready = 1'b0;
        dut_accepts = 0;
        repeat (8) step();
        chk("bp_accepts", 32'(dut_accepts), 32'd4);
        chk("bp_hold_valid", 32'(s_iv), 32'd0);
        chk("bp_hold_addr", s_ia, 32'h10);
        fready = 1'b1;
        step();
        fready = 1'b0;
        step();
        chk("bp_refill_valid", 32'(s_iv), 32'd1);
        chk("bp_refill_addr", s_ia, 32'h10);
        repeat (4) step();
        chk("bp_accepts_after_pop", 32'(dut_accepts), 32'd5);

        // Memory stall
        do_reset();
        fetch_en = 1'b1; iready = 1'b0; fready = 1'b1;
        dut_accepts = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(s_iv), 32'd1);
            chk("stall_addr", s_ia, 32'h0);
        end
        iready = 1'b1;
        step();
        iready = 1'b0;
        repeat (3) step();
        chk("stall_accepts", 32'(dut_accepts), 32'd1);

        // Redirect with two requests in flight
        do_reset();
        lat_lo = 3; lat_hi = 3;
        fetch_en = 1'b1; iready = 1'b1; fready = 1'b1;
        repeat (4) step();
        fetch_en = 1'b0;
        step();
        chk("rd_outstanding_before", 32'(outst), 32'd2);
        mem_hold = 1'b1; redir = 1'b1; redir_pc = 32'h2003;
        step();
        chk("rd_fvalid_at_redirect", 32'(s_fv), 32'd0);
        redir = 1'b0; mem_hold = 1'b0; fetch_en = 1'b1;
        step();
        chk("rd_next_valid", 32'(s_iv), 32'd1);
        chk("rd_next_addr", s_ia, 32'h2000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_fv) found = 1'b1;
        end
        chk("rd_first_found", 32'(found), 32'd1);
        chk("rd_first_pc", s_fp, 32'h2000);
        chk("rd_first_instr", s_fi, 32'h2100);

        // Redirect coincident with a response and a pop
        do_reset();
        lat_lo = 2; lat_hi = 2;
        fetch_en = 1'b1; iready = 1'b1; fready = 1'b1;
        repeat (2) step();
        fetch_en = 1'b0;
        step();
        chk("co_outstanding_before", 32'(outst), 32'd1);
        redir = 1'b1; redir_pc = 32'h300;
        step();
        chk("co_fvalid", 32'(s_fv), 32'd0);
        redir = 1'b0;
        chk("co_outstanding_after", 32'(outst), 32'd0);
        fetch_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_fv) found = 1'b1;
        end
        chk("co_first_found", 32'(found), 32'd1);
        chk("co_first_pc", s_fp, 32'h300);
        chk("co_first_instr", s_fi, 32'h400);

        // Asynchronous reset mid-stream
        do_reset();
        lat_lo = 3; lat_hi = 3;
        fetch_en = 1'b1; iready = 1'b1; fready = 1'b1;
        repeat (4) step();
        chk("ar_outstanding_before", 32'(outst), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_ivalid", 32'(ivalid), 32'd0);
        chk("ar_iaddr", iaddr, RPC);
        chk("ar_fvalid", 32'(fvalid), 32'd0);
        chk("ar_fpc", fpc, 32'h0);
        chk("ar_finstr", finstr, 32'h0);
        chk("ar_outst", 32'(outst), 32'd0);
        model_reset();
        rvalid = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("ar_restart_valid", 32'(s_iv), 32'd1);
        chk("ar_restart_addr", s_ia, RPC);
        repeat (10) step();

        // Randomized traffic against the reference model
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            fetch_en = ($urandom % 8) != 0;
            iready   = ($urandom % 4) != 0;
            fready   = ($urandom % 3) != 0;
            redir    = ($urandom % 30) == 0;
            redir_pc = $urandom;
            mem_hold = ($urandom % 5) == 0;
            step();
        end
        redir = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch front-end that sits directly upstream of the instruction port of the dual-port memory controller. It generates sequential PCs and issues word reads over the valid/ready request handshake. It collects in-order read responses into a small prefetch FIFO of {pc, instr} pairs for the decode stage. It handles branch/exception redirects by flushing the FIFO and discarding responses that are still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, 2..16. Also bounds fifo_count+outstanding.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- fetch_en_in  input  1  1 = issue new requests; 0 = stop issuing; responses still collected.
- redirect_valid_in  input  1  single-cycle redirect pulse.
- redirect_pc_in  input  32  redirect target; bits [1:0] ignored, treated as 0.
- instr_addr_out  output  32  request address to memory instruction port.
- instr_valid_out  output  1  request valid.
- instr_ready_in  input  1  memory accepts request when high with valid.
- instr_rdata_valid_in  input  1  read response valid; responses return in request order.
- instr_rdata_in  input  32  read response data.
- fetch_valid_out  output  1  FIFO head valid toward decode.
- fetch_pc_out  output  32  PC of FIFO head; 0 when empty.
- fetch_instr_out  output  32  instruction of FIFO head; 0 when empty.
- fetch_ready_in  input  1  decode pops head when high with fetch_valid_out.
- outstanding_out  output  $clog2(FIFO_DEPTH)+1  accepted requests not yet answered, including ones to be dropped.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC and resp_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - instr_valid_out=0, instr_addr_out=RESET_PC, fetch_valid_out=0, fetch_pc_out=0, fetch_instr_out=0, outstanding_out=0.
  - First request may assert in the first cycle after rst deasserts.
- Issue rule:
  - instr_valid_out = fetch_en_in & ~redirect_valid_in & ((fifo_count + outstanding) < FIFO_DEPTH).
  - instr_addr_out = fetch_pc.
  - Accept = instr_valid_out & instr_ready_in. On accept: fetch_pc += 4 (wraps modulo 2^32) and outstanding += 1.
  - Without accept, instr_addr_out is held stable.
- Credit guarantee: the FIFO can never overflow. Every accepted request has a reserved slot.
- Response handling, when instr_rdata_valid_in=1:
  - outstanding -= 1 in all cases.
  - If drop_cnt>0 or redirect_valid_in: the response is discarded, and drop_cnt -= 1 if drop_cnt>0.
  - Otherwise {resp_pc, instr_rdata_in} is pushed and resp_pc += 4.
  - Accept, response and pop in the same cycle are all legal. Counters update by net sum.
- Output side:
  - fetch_valid_out = FIFO non-empty & ~redirect_valid_in.
  - Pop = fetch_valid_out & fetch_ready_in.
  - A push into an empty FIFO becomes visible the next cycle; there is no bypass, so minimum request-to-decode latency is memory latency + 1.
- Redirect, when redirect_valid_in=1 (highest priority):
  - FIFO cleared; fetch_pc and resp_pc take {redirect_pc_in[31:2], 2'b00}.
  - No accept occurs this cycle. A pending unaccepted request is abandoned.
  - drop_cnt <= outstanding - (instr_rdata_valid_in ? 1 : 0).
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed from current outstanding.
  - First post-redirect request is issued the next cycle if credits allow.
- fetch_en_in=0: no new issue; in-flight responses are still pushed or dropped normally.
- Response with outstanding=0: protocol error; ignored, counters unchanged.
- outstanding_out mirrors the outstanding counter register.

Test Plan:
- Reset and stream: memory has 1-cycle latency, always ready, fetch_ready_in=1, and word at addr A = A+32'h100. Required: pairs (0x0,0x100), (0x4,0x104), (0x8,0x108)… with fetch_valid_out first high in cycle 3 after reset release; outstanding_out never exceeds 4.
- Backpressure: fetch_ready_in=0 with FIFO_DEPTH=4. Required: exactly 4 requests accepted (0x0..0xC), then instr_valid_out=0 and instr_addr_out=0x10 held. After one pop, exactly one new request to 0x10 is issued.
- Memory stall: instr_ready_in=0 for 5 cycles. Required: instr_valid_out=1 and instr_addr_out=0x0 stable throughout; a single accept when ready rises.
- Redirect with in-flight: 2 outstanding (0x8, 0xC), redirect_pc_in=0x2003. Required: FIFO empties the same cycle, the next request addr is 0x2000, both old responses are dropped, and the first fetch output is (0x2000, 0x2100).
- Redirect coincident with a response and a pop: outstanding=1, response arrives and fetch_ready_in=1 in the redirect cycle. Required: fetch_valid_out=0 that cycle, response dropped, drop_cnt=0, outstanding_out=0 next cycle.
- Async reset mid-stream: rst=0 between clock edges with 3 outstanding. Required: all outputs take reset values immediately; after release, fetch restarts at RESET_PC and stale responses are not pushed (bench must not return them).
